rvfi_commit_checker: RTL and testbench

- Consumer end of the RVFI commit stream: samples the retirement signals driven by the pipeline and checks every committed instruction against architectural invariants.
- Keeps a shadow register file, the expected next order and the expected next PC.
- Reports sticky error bits on the 16-bit errcode, plus halt/done status, to the testbench top.
- Synthesizable, so it can also run on FPGA builds.

---
 rtl/rvfi_commit_checker.sv | 151 +++++++++++++++
 tb/tb_rvfi_commit_checker.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rvfi_commit_checker.sv
// RVFI commit-stream checker: shadow regfile, order/PC tracking, watchdog and sticky errcode.
// Optional memory byte-mask checking is compiled in with `define RVFI_MEM_CHECK_EN.
module rvfi_commit_checker #(
    parameter logic [31:0] RESET_PC        = 32'h4000_0000,
    parameter int unsigned WATCHDOG_CYCLES = 10000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        commit,
    input  logic        halt,
    input  logic [63:0] order,
    input  logic [31:0] inst,
    input  logic        trap,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    input  logic [31:0] rs1_rdata,
    input  logic [31:0] rs2_rdata,
    input  logic        load_regfile,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] rd_wdata,
    input  logic [31:0] pc_rdata,
    input  logic [31:0] pc_wdata,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_rmask,
    input  logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata,
    input  logic [31:0] mem_wdata,
    output logic [15:0] errcode,
    output logic        error,
    output logic        halted,
    output logic [63:0] commit_count,
    output logic [63:0] first_err_order
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } state_t;

    localparam logic [31:0] WD_LIMIT = WATCHDOG_CYCLES - 1;

    state_t      state;
    state_t      state_next;
    logic [31:0] shadow [32];
    logic [63:0] exp_order;
    logic [31:0] exp_pc;
    logic [31:0] wd_cnt;
    logic [15:0] chk;
    logic        wd_expire;
    logic        mem_err;
    logic [31:0] rs1_shadow;
    logic [31:0] rs2_shadow;

    // x0 is hardwired to zero regardless of shadow contents
    assign rs1_shadow = (rs1_addr == 5'd0) ? 32'd0 : shadow[rs1_addr];
    assign rs2_shadow = (rs2_addr == 5'd0) ? 32'd0 : shadow[rs2_addr];

`ifdef RVFI_MEM_CHECK_EN
    function automatic logic mask_legal(input logic [3:0] m);
        case (m)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: mask_legal = 1'b1;
            default:                   mask_legal = 1'b0;
        endcase
    endfunction

    assign mem_err = ((mem_rmask != 4'd0) && (mem_wmask != 4'd0))
                   || !mask_legal(mem_rmask) || !mask_legal(mem_wmask)
                   || ((mem_addr[1:0] != 2'd0) && ((mem_rmask | mem_wmask) != 4'd0));

    logic unused_inputs;
    assign unused_inputs = ^{inst, mem_rdata, mem_wdata, mem_addr[31:2]};
`else
    assign mem_err = 1'b0;

    logic unused_inputs;
    assign unused_inputs = ^{inst, mem_rdata, mem_wdata, mem_addr, mem_rmask, mem_wmask};
`endif

    always_comb begin
        chk = '0;
        if (commit) begin
            chk[0] = (order != exp_order);
            chk[1] = (pc_rdata != exp_pc);
            chk[2] = (rs1_rdata != rs1_shadow);
            chk[3] = (rs2_rdata != rs2_shadow);
            chk[4] = load_regfile && (rd_addr == 5'd0) && (rd_wdata != 32'd0);
            chk[5] = trap;
            chk[6] = (pc_wdata[1:0] != 2'd0);
            chk[7] = mem_err;
            chk[9] = (state == HALTED);
        end
    end

    assign wd_expire = (WATCHDOG_CYCLES != 0) && (state == RUN) && !commit
                     && (wd_cnt == WD_LIMIT);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (commit) state_next = halt ? HALTED : RUN;
            RUN:     if (commit && halt) state_next = HALTED;
            HALTED:  state_next = HALTED;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            errcode         <= '0;
            first_err_order <= '0;
            commit_count    <= '0;
            exp_order       <= '0;
            exp_pc          <= RESET_PC;
            wd_cnt          <= '0;
        end else begin
            if (errcode == 16'd0) begin
                if (commit && (chk != 16'd0)) first_err_order <= order;
                else if (wd_expire)           first_err_order <= exp_order;
            end
            errcode <= errcode | chk | {7'd0, wd_expire, 8'd0};
            // Resynchronise to the DUT's own values so one slip flags once
            if (commit) begin
                exp_order    <= order + 64'd1;
                exp_pc       <= pc_wdata;
                commit_count <= commit_count + 64'd1;
            end
            if ((state != RUN) || commit)  wd_cnt <= '0;
            else if (wd_cnt != WD_LIMIT)   wd_cnt <= wd_cnt + 32'd1;
        end
    end

    // Written at the commit edge, so this commit's source checks see old contents
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) shadow[i] <= '0;
        end else if (commit && load_regfile && (rd_addr != 5'd0)) begin
            shadow[rd_addr] <= rd_wdata;
        end
    end

    assign error  = |errcode;
    assign halted = (state == HALTED);

endmodule

// File: tb/tb_rvfi_commit_checker.sv
// Directed-vector bench for rvfi_commit_checker (watchdog shortened to 16 cycles).
module tb_rvfi_commit_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        commit, halt, trap, load_regfile;
    logic [63:0] order;
    logic [31:0] inst;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [31:0] rs1_rdata, rs2_rdata, rd_wdata;
    logic [31:0] pc_rdata, pc_wdata, mem_addr, mem_rdata, mem_wdata;
    logic [3:0]  mem_rmask, mem_wmask;
    logic [15:0] errcode;
    logic        error, halted;
    logic [63:0] commit_count, first_err_order;

    int n_checks = 0;
    int n_passed = 0;

    localparam logic [31:0] PC0 = 32'h4000_0000;

    always #5 clk = ~clk;

    rvfi_commit_checker #(
        .RESET_PC       (PC0),
        .WATCHDOG_CYCLES(16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .commit         (commit),
        .halt           (halt),
        .order          (order),
        .inst           (inst),
        .trap           (trap),
        .rs1_addr       (rs1_addr),
        .rs2_addr       (rs2_addr),
        .rs1_rdata      (rs1_rdata),
        .rs2_rdata      (rs2_rdata),
        .load_regfile   (load_regfile),
        .rd_addr        (rd_addr),
        .rd_wdata       (rd_wdata),
        .pc_rdata       (pc_rdata),
        .pc_wdata       (pc_wdata),
        .mem_addr       (mem_addr),
        .mem_rmask      (mem_rmask),
        .mem_wmask      (mem_wmask),
        .mem_rdata      (mem_rdata),
        .mem_wdata      (mem_wdata),
        .errcode        (errcode),
        .error          (error),
        .halted         (halted),
        .commit_count   (commit_count),
        .first_err_order(first_err_order)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic clear_inputs;
        commit = 0; halt = 0; trap = 0; load_regfile = 0;
        order = 0; inst = 32'h0000_0013;
        rs1_addr = 0; rs2_addr = 0; rd_addr = 0;
        rs1_rdata = 0; rs2_rdata = 0; rd_wdata = 0;
        pc_rdata = 0; pc_wdata = 0;
        mem_addr = 0; mem_rmask = 0; mem_wmask = 0; mem_rdata = 0; mem_wdata = 0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
    endtask

    // Side fields (regs, mem, trap, halt) are set by the caller before the call.
    task automatic commit_insn(input logic [63:0] o, input logic [31:0] pc, input logic [31:0] npc);
        commit = 1; order = o; pc_rdata = pc; pc_wdata = npc;
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        rst = 0;

        // Reset state and clean in-order stream
        do_reset();
        check("rst_errcode", errcode, 0);
        check("rst_error", error, 0);
        check("rst_halted", halted, 0);
        check("rst_count", commit_count, 0);
        check("rst_first_err", first_err_order, 0);
        commit_insn(0, PC0,     PC0 + 4);
        commit_insn(1, PC0 + 4, PC0 + 8);
        commit_insn(2, PC0 + 8, PC0 + 12);
        check("seq_errcode", errcode, 0);
        check("seq_count", commit_count, 3);
        check("seq_halted", halted, 0);

        // Shadow write then matching read
        do_reset();
        load_regfile = 1; rd_addr = 5; rd_wdata = 32'hDEAD_BEEF;
        commit_insn(0, PC0, PC0 + 4);
        rs1_addr = 5; rs1_rdata = 32'hDEAD_BEEF;
        load_regfile = 1; rd_addr = 5; rd_wdata = 32'h0000_1234;
        commit_insn(1, PC0 + 4, PC0 + 8);
        check("rs1_match", errcode, 0);
        rs2_addr = 5; rs2_rdata = 32'h0000_1234;
        commit_insn(2, PC0 + 8, PC0 + 12);
        check("rs2_after_write", errcode, 0);
        rs2_addr = 5; rs2_rdata = 32'h0;
        commit_insn(3, PC0 + 12, PC0 + 16);
        check("rs2_mismatch", errcode, 16'h0008);
        check("rs2_first_err", first_err_order, 3);

        // Stale source value
        do_reset();
        load_regfile = 1; rd_addr = 5; rd_wdata = 32'hDEAD_BEEF;
        commit_insn(0, PC0, PC0 + 4);
        rs1_addr = 5; rs1_rdata = 32'h0;
        commit_insn(1, PC0 + 4, PC0 + 8);
        check("rs1_mismatch", errcode, 16'h0004);
        check("rs1_first_err", first_err_order, 1);
        check("rs1_error", error, 1);

        // Reset mid-run clears everything
        do_reset();
        check("midrst_errcode", errcode, 0);
        check("midrst_count", commit_count, 0);
        check("midrst_first_err", first_err_order, 0);

        // Order slip flags once
        commit_insn(0, PC0,      PC0 + 4);
        commit_insn(1, PC0 + 4,  PC0 + 8);
        commit_insn(3, PC0 + 8,  PC0 + 12);
        check("order_slip", errcode, 16'h0001);
        commit_insn(4, PC0 + 12, PC0 + 16);
        check("order_resync", errcode, 16'h0001);
        check("order_first_err", first_err_order, 3);

        // Write to x0, then x0 still reads zero
        do_reset();
        load_regfile = 1; rd_addr = 0; rd_wdata = 7;
        commit_insn(0, PC0, PC0 + 4);
        check("x0_write", errcode, 16'h0010);
        rs1_addr = 0; rs1_rdata = 0;
        commit_insn(1, PC0 + 4, PC0 + 8);
        check("x0_read", errcode, 16'h0010);

        // PC mismatch with resync, trap, misaligned next PC
        do_reset();
        commit_insn(0, PC0 + 16, PC0 + 20);
        check("pc_mismatch", errcode, 16'h0002);
        commit_insn(1, PC0 + 20, PC0 + 24);
        check("pc_resync", errcode, 16'h0002);
        trap = 1;
        commit_insn(2, PC0 + 24, PC0 + 28);
        check("trap", errcode, 16'h0022);
        commit_insn(3, PC0 + 28, PC0 + 30);
        check("npc_misaligned", errcode, 16'h0062);
        check("pc_first_err", first_err_order, 0);

        // Halt then commit after halt
        do_reset();
        for (int i = 0; i < 5; i++) commit_insn(i, PC0 + 4 * i, PC0 + 4 * i + 4);
        check("pre_halt", halted, 0);
        halt = 1;
        commit_insn(5, PC0 + 20, PC0 + 24);
        check("halted", halted, 1);
        check("halt_count", commit_count, 6);
        check("halt_errcode", errcode, 0);
        commit_insn(6, PC0 + 24, PC0 + 28);
        check("post_halt", errcode, 16'h0200);
        check("post_halt_first", first_err_order, 6);

        // Watchdog inactive in IDLE
        do_reset();
        idle_cycles(20);
        check("wd_idle", errcode, 0);

        // Watchdog boundary: 15 idle cycles clean, 16th expires
        commit_insn(0, PC0, PC0 + 4);
        idle_cycles(15);
        check("wd_pre", errcode, 0);
        idle_cycles(1);
        check("wd_expire", errcode, 16'h0100);
        check("wd_first_err", first_err_order, 1);
        idle_cycles(5);
        check("wd_sticky", errcode, 16'h0100);

        // Memory mask checks
        do_reset();
        mem_rmask = 4'b1111; mem_addr = 32'h100;
        commit_insn(0, PC0, PC0 + 4);
        check("mem_legal", errcode, 0);
        mem_rmask = 4'b0101;
        commit_insn(1, PC0 + 4, PC0 + 8);
`ifdef RVFI_MEM_CHECK_EN
        check("mem_bad_mask", errcode, 16'h0080);
`else
        check("mem_bad_mask", errcode, 16'h0000);
`endif
        do_reset();
        mem_wmask = 4'b0011; mem_addr = 32'h102;
        commit_insn(0, PC0, PC0 + 4);
`ifdef RVFI_MEM_CHECK_EN
        check("mem_misaligned", errcode, 16'h0080);
`else
        check("mem_misaligned", errcode, 16'h0000);
`endif

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
